// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave with a small register file, oversampled in the CLK domain.
// Decodes 24-bit R/W frames, answers reads on MISO and reports committed writes.
module spi_slave_regfile #(
  parameter int NUM_REGS    = 16,
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              spi_sck,
  input  logic              spi_cs,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [DATA_W-1:0] sta_in,
  output logic              wr_stb,
  output logic [6:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_err,
  output logic [15:0]       frame_cnt
);

  localparam int FRAME_BITS = 8 + DATA_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_DATA,
    S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_stateNext;

  logic [SYNC_STAGES-1:0]  r_sckSync;
  logic [SYNC_STAGES-1:0]  r_csSync;
  logic [SYNC_STAGES-1:0]  r_mosiSync;
  logic                    r_sckDly;
  logic                    r_csDly;

  logic                    w_sck;
  logic                    w_cs;
  logic                    w_mosi;
  logic                    w_sckRise;
  logic                    w_sckFall;
  logic                    w_csRise;
  logic                    w_csFall;

  logic [7:0]              r_bitCnt;
  logic                    r_extra;
  logic                    r_rw;
  logic [6:0]              r_addr;
  logic [DATA_W-2:0]       r_shiftReg;
  logic [DATA_W-1:0]       r_shiftOut;
  logic [DATA_W-1:0]       r_regs [1:NUM_REGS-1];

  logic [7:0]              w_cmdByte;
  logic [DATA_W-1:0]       w_dataWord;
  logic [DATA_W-1:0]       w_rdData;
  logic                    w_addrValid;

  logic                    w_frameErr;
  logic                    w_clrCnt;
  logic                    w_shiftIn;
  logic                    w_latchCmd;
  logic                    w_frameDone;
  logic                    w_markExtra;

  // Pin synchronizers reset to the idle bus levels so a low cs at release reads as a fall
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_sckSync  <= '0;
      r_csSync   <= '1;
      r_mosiSync <= '0;
      r_sckDly   <= 1'b0;
      r_csDly    <= 1'b1;
    end else begin
      r_sckSync  <= {r_sckSync[SYNC_STAGES-2:0], spi_sck};
      r_csSync   <= {r_csSync[SYNC_STAGES-2:0], spi_cs};
      r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], spi_mosi};
      r_sckDly   <= r_sckSync[SYNC_STAGES-1];
      r_csDly    <= r_csSync[SYNC_STAGES-1];
    end
  end

  assign w_sck       = r_sckSync[SYNC_STAGES-1];
  assign w_cs        = r_csSync[SYNC_STAGES-1];
  assign w_mosi      = r_mosiSync[SYNC_STAGES-1];
  assign w_sckRise   = w_sck & ~r_sckDly;
  assign w_sckFall   = ~w_sck & r_sckDly;
  assign w_csRise    = w_cs & ~r_csDly;
  assign w_csFall    = ~w_cs & r_csDly;
  assign spi_miso_oe = ~w_cs;

  assign w_cmdByte   = {r_shiftReg[6:0], w_mosi};
  assign w_dataWord  = {r_shiftReg, w_mosi};
  assign w_addrValid = (r_addr != 7'd0) && ({1'b0, r_addr} < 8'(NUM_REGS));

  always_comb begin
    w_rdData = '0;
    if (w_cmdByte[6:0] == 7'd0) begin
      w_rdData = sta_in;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (w_cmdByte[6:0] == 7'(i)) begin
          w_rdData = r_regs[i];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // A cs rise wins over any sck edge seen in the same cycle
  always_comb begin
    w_stateNext = r_state;
    w_frameErr  = 1'b0;
    w_clrCnt    = 1'b0;
    w_shiftIn   = 1'b0;
    w_latchCmd  = 1'b0;
    w_frameDone = 1'b0;
    w_markExtra = 1'b0;
    if (w_csRise) begin
      w_stateNext = S_IDLE;
      if ((r_state == S_CMD || r_state == S_DATA) && r_bitCnt != 8'd0) begin
        w_frameErr = 1'b1;
      end
      if (r_state == S_DONE && r_extra) begin
        w_frameErr = 1'b1;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_csFall) begin
            w_stateNext = S_CMD;
            w_clrCnt    = 1'b1;
          end
        end
        S_CMD: begin
          if (w_sckRise) begin
            w_shiftIn = 1'b1;
            if (r_bitCnt == 8'd7) begin
              w_latchCmd  = 1'b1;
              w_stateNext = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_sckRise) begin
            w_shiftIn = 1'b1;
            if (r_bitCnt == 8'(FRAME_BITS - 1)) begin
              w_frameDone = 1'b1;
              w_stateNext = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (w_sckRise) begin
            w_markExtra = 1'b1;
          end
        end
        default: w_stateNext = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_bitCnt   <= '0;
      r_extra    <= 1'b0;
      r_rw       <= 1'b0;
      r_addr     <= '0;
      r_shiftReg <= '0;
      r_shiftOut <= '0;
      spi_miso   <= 1'b0;
      wr_stb     <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      wr_stb    <= 1'b0;
      frame_err <= w_frameErr;
      if (w_clrCnt) begin
        r_bitCnt <= '0;
        r_extra  <= 1'b0;
      end
      if (w_shiftIn) begin
        r_shiftReg <= {r_shiftReg[DATA_W-3:0], w_mosi};
        r_bitCnt   <= r_bitCnt + 8'd1;
      end
      if (w_latchCmd) begin
        r_rw       <= w_cmdByte[7];
        r_addr     <= w_cmdByte[6:0];
        r_shiftOut <= w_cmdByte[7] ? w_rdData : '0;
      end
      if (w_frameDone) begin
        frame_cnt <= frame_cnt + 16'd1;
        if (!r_rw && w_addrValid) begin
          wr_stb  <= 1'b1;
          wr_addr <= r_addr;
          wr_data <= w_dataWord;
        end
      end
      if (w_markExtra) begin
        r_extra <= 1'b1;
      end
      // MISO only moves on sck falls; frame boundaries park it low for the next CMD phase
      if (w_csRise || w_csFall) begin
        spi_miso <= 1'b0;
      end else if (w_sckFall) begin
        if (r_state == S_DATA && r_rw) begin
          spi_miso   <= r_shiftOut[DATA_W-1];
          r_shiftOut <= {r_shiftOut[DATA_W-2:0], 1'b0};
        end else begin
          spi_miso <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_frameDone && !r_rw) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (r_addr == 7'(i)) begin
          r_regs[i] <= w_dataWord;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Randomized bench for spi_slave_regfile: drives SPI frames as a master and
// compares against a frame-level register file model.
module tb_spi_slave_regfile;

  localparam int NUM_REGS = 16;
  localparam int DATA_W   = 16;

  logic              CLK = 1'b0;
  logic              rst_n = 1'b0;
  logic              spi_sck = 1'b0;
  logic              spi_cs = 1'b1;
  logic              spi_mosi = 1'b0;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic [DATA_W-1:0] sta_in = '0;
  logic              wr_stb;
  logic [6:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              frame_err;
  logic [15:0]       frame_cnt;

  spi_slave_regfile #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .rst_n(rst_n), .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .sta_in(sta_in), .wr_stb(wr_stb),
    .wr_addr(wr_addr), .wr_data(wr_data), .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          fails = 0;
  int          stbSeen = 0;
  int          errSeen = 0;
  logic [6:0]  stbAddr = '0;
  logic [15:0] stbData = '0;

  logic [15:0] modelRegs [0:127];
  logic [15:0] modelCnt = '0;
  logic [6:0]  modelWrAddr = '0;
  logic [15:0] modelWrData = '0;

  // Count high cycles of the strobes so a stretched pulse shows up as a count above one
  always @(negedge CLK) begin
    if (wr_stb) begin
      stbSeen = stbSeen + 1;
      stbAddr = wr_addr;
      stbData = wr_data;
    end
    if (frame_err) errSeen = errSeen + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 128; i++) modelRegs[i] = '0;
    modelCnt    = '0;
    modelWrAddr = '0;
    modelWrData = '0;
  endtask

  task automatic applyStimulus(input logic [23:0] frame, input int nBits, input int half,
                               input logic [15:0] sta);
    logic [15:0] misoWord;
    logic [15:0] expMiso;
    logic        rw;
    logic [6:0]  addr;
    logic [15:0] data;
    int          expStb;
    int          expErr;
    misoWord = '0;
    rw       = frame[23];
    addr     = frame[22:16];
    data     = frame[15:0];
    sta_in   = sta;
    stbSeen  = 0;
    errSeen  = 0;
    @(negedge CLK);
    spi_cs = 1'b0;
    repeat (5) @(negedge CLK);
    checkOutput("miso_oe_active", 32'(spi_miso_oe), 32'd1);
    for (int k = 0; k < nBits; k++) begin
      spi_mosi = (k < 24) ? frame[23-k] : 1'($urandom_range(0, 1));
      repeat (half) @(negedge CLK);
      if (k >= 8 && k < 24) misoWord[23-k] = spi_miso;
      spi_sck = 1'b1;
      repeat (half) @(negedge CLK);
      spi_sck = 1'b0;
    end
    repeat (half) @(negedge CLK);
    spi_cs = 1'b1;
    repeat (8) @(negedge CLK);

    expStb = 0;
    expErr = ((nBits > 0 && nBits < 24) || nBits > 24) ? 1 : 0;
    if (nBits >= 24) begin
      expMiso = '0;
      if (rw) begin
        if (addr == 7'd0) expMiso = sta;
        else if (int'(addr) < NUM_REGS) expMiso = modelRegs[addr];
      end else if (addr != 7'd0 && int'(addr) < NUM_REGS) begin
        modelRegs[addr] = data;
        modelWrAddr     = addr;
        modelWrData     = data;
        expStb          = 1;
      end
      modelCnt = modelCnt + 16'd1;
      checkOutput("miso_word", 32'(misoWord), 32'(expMiso));
    end
    checkOutput("wr_stb_cycles", 32'(stbSeen), 32'(expStb));
    if (expStb == 1) begin
      checkOutput("wr_addr_at_stb", 32'(stbAddr), 32'(addr));
      checkOutput("wr_data_at_stb", 32'(stbData), 32'(data));
    end
    checkOutput("wr_addr_last", 32'(wr_addr), 32'(modelWrAddr));
    checkOutput("wr_data_last", 32'(wr_data), 32'(modelWrData));
    checkOutput("frame_err_cycles", 32'(errSeen), 32'(expErr));
    checkOutput("frame_cnt", 32'(frame_cnt), 32'(modelCnt));
    checkOutput("miso_oe_idle", 32'(spi_miso_oe), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_miso"}, 32'(spi_miso), 32'd0);
    checkOutput({tag, "_miso_oe"}, 32'(spi_miso_oe), 32'd0);
    checkOutput({tag, "_wr_stb"}, 32'(wr_stb), 32'd0);
    checkOutput({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    checkOutput({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    checkOutput({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    checkOutput({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
  endtask

  task automatic applyMidReset(input logic [23:0] frame, input int bitsBefore);
    errSeen = 0;
    @(negedge CLK);
    spi_cs = 1'b0;
    repeat (5) @(negedge CLK);
    for (int k = 0; k < bitsBefore; k++) begin
      spi_mosi = frame[23-k];
      repeat (5) @(negedge CLK);
      spi_sck = 1'b1;
      repeat (5) @(negedge CLK);
      spi_sck = 1'b0;
    end
    repeat (2) @(negedge CLK);
    rst_n = 1'b0;
    repeat (2) @(negedge CLK);
    checkResetOutputs("midreset");
    rst_n = 1'b1;
    clearModel();
    repeat (6) @(negedge CLK);
    spi_cs = 1'b1;
    repeat (8) @(negedge CLK);
    checkOutput("midreset_no_err", 32'(errSeen), 32'd0);
    checkOutput("midreset_cnt", 32'(frame_cnt), 32'd0);
  endtask

  initial begin
    logic [23:0] frame;
    logic [6:0]  addr;
    int          nBits;
    clearModel();
    repeat (3) @(negedge CLK);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge CLK);

    applyStimulus(24'h05A5C3, 24, 5, 16'h0000);
    applyStimulus(24'h850000, 24, 5, 16'h0000);
    applyStimulus(24'h800000, 24, 5, 16'h0003);
    applyStimulus(24'h00FFFF, 24, 5, 16'h0003);
    applyStimulus(24'h800000, 24, 5, 16'h0003);
    applyStimulus(24'hFF0000, 24, 5, 16'h0003);
    applyStimulus(24'h20BEEF, 24, 5, 16'h0003);
    applyStimulus(24'h035555, 12, 5, 16'h0000);
    applyStimulus(24'h830000, 24, 5, 16'h0000);
    applyStimulus(24'h021234, 26, 5, 16'h0000);
    applyStimulus(24'h820000, 24, 5, 16'h0000);
    applyStimulus(24'h000000, 0, 5, 16'h0000);

    applyMidReset(24'h03ABCD, 14);
    applyStimulus(24'h830000, 24, 5, 16'h0000);
    applyStimulus(24'h850000, 24, 5, 16'h0000);

    // Minimum legal SCK timing, alternating writes and read-backs
    for (int i = 0; i < 6; i++) begin
      addr = 7'($urandom_range(1, NUM_REGS - 1));
      applyStimulus({1'b0, addr, 16'($urandom)}, 24, 4, 16'($urandom));
      applyStimulus({1'b1, addr, 16'h0000}, 24, 4, 16'($urandom));
    end

    for (int i = 0; i < 40; i++) begin
      addr = ($urandom_range(0, 9) == 0) ? 7'h7F : 7'($urandom_range(0, NUM_REGS + 3));
      frame = {1'($urandom_range(0, 1)), addr, 16'($urandom)};
      case ($urandom_range(0, 9))
        0:       nBits = $urandom_range(1, 23);
        1:       nBits = $urandom_range(25, 27);
        default: nBits = 24;
      endcase
      applyStimulus(frame, nBits, $urandom_range(4, 6), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/spi_slave_regfile.md
Name: spi_slave_regfile

Overview:
- Synthesizable SPI slave (mode 0, CPOL=0/CPHA=0, MSB-first) with an internal register file.
- It is the chip-side responder for the SPI master driving spi_sck/spi_mosi/spi_cs/spi_miso.
- Serves as an on-FPGA loopback target for the SPI master path and as a model of the test chip's configuration port.
- Oversamples the SPI pins in the CLK domain, decodes 24-bit read/write frames, updates registers, returns read data on MISO, and reports writes to fabric.

Parameters:
- NUM_REGS, 16, number of registers; address 0 is read-only status; valid range 2..128.
- DATA_W, 16, register width; fixed frame data field width.
- SYNC_STAGES, 2, synchronizer depth for sck/cs/mosi; minimum 2.

Ports:
- CLK  input  1  fabric clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- spi_sck  input  1  SPI clock from master, asynchronous to CLK.
- spi_cs  input  1  chip select, active low.
- spi_mosi  input  1  master-out data.
- spi_miso  output  1  slave-out data.
- spi_miso_oe  output  1  MISO output enable; 1 only while spi_cs is low (synchronized).
- sta_in  input  DATA_W  live status word returned on reads of address 0.
- wr_stb  output  1  one-CLK pulse on a committed register write.
- wr_addr  output  7  address of the last committed write.
- wr_data  output  DATA_W  data of the last committed write.
- frame_err  output  1  one-CLK pulse when a frame ends with a bit count other than 24.
- frame_cnt  output  16  count of completed 24-bit frames; wraps 0xFFFF->0.

Behaviour:
- Reset (async assert, sync release): all registers 0, state IDLE, spi_miso=0, spi_miso_oe=0, wr_stb=0, wr_addr=0, wr_data=0, frame_err=0, frame_cnt=0, synchronizers at idle levels (sck=0, cs=1, mosi=0).
- Pin synchronization:
  - sck, cs and mosi each pass through SYNC_STAGES flops.
  - Edges are detected against one further delayed copy.
  - mosi is sampled from the synchronized value at the detected sck rise.
  - Required SCK period: at least 8 CLK cycles, each phase at least 4 CLK cycles.
  - CS low to first SCK rise: at least 4 CLK cycles.
- Frame format, 24 bits: bit23 R/W (1=read), bits22:16 addr[6:0], bits15:0 data.
- State machine:
  - IDLE -> CMD on cs fall; bit counter cleared.
  - CMD: shift 8 bits on sck rises. On the 8th rise, latch addr and rw. For a read, load the shift-out register with sta_in (addr 0), regs[addr] (1..NUM_REGS-1) or 0 (addr >= NUM_REGS). Go to DATA.
  - DATA: shift 16 bits. On the 16th rise, go to DONE. For a write with 1 <= addr < NUM_REGS, also update regs[addr] and pulse wr_stb with wr_addr/wr_data valid the same cycle.
  - Writes to addr 0 or out of range are dropped with no wr_stb. frame_cnt increments on the 24th rise, for reads and writes.
  - DONE: ignore further sck edges; stay until cs rises.
  - cs rise in any state -> IDLE.
- MISO timing:
  - spi_miso is updated only on detected sck falls in the CLK domain.
  - At the 8th fall, MISO = data bit15; each later fall presents the next bit down to bit0.
  - MISO = 0 during CMD, during DONE and for write frames.
  - spi_miso_oe follows synchronized ~cs.
- Error handling:
  - cs rise in CMD/DATA with 1..23 bits received pulses frame_err; no commit, frame_cnt unchanged.
  - cs rise from DONE with extra sck rises (>24) after bit 24 pulses frame_err; the 24-bit commit is kept.
  - cs low/high with zero sck rises causes no error.
- Simultaneous events: a cs rise detected in the same CLK as an sck rise takes priority; the sck edge is discarded.
- Reset mid-frame aborts immediately; no commit and no frame_err.

Test Plan:
- Write 0x0005=0xA5C3 (frame 0x05A5C3) -> wr_stb 1 cycle, wr_addr=5, wr_data=0xA5C3, frame_cnt=1; then read addr 5 (0x850000) -> MISO returns 0xA5C3 MSB-first, frame_cnt=2.
- sta_in=0x0003, read addr 0 (0x800000) -> MISO 0x0003; write addr 0 (0x00FFFF) -> no wr_stb, subsequent read still returns sta_in.
- Read addr 0x7F with NUM_REGS=16 -> MISO 0x0000; write to addr 0x20 -> no wr_stb, frame_cnt increments.
- Raise cs after 12 bits of a write to addr 3 -> frame_err pulse, regs[3] unchanged, frame_cnt unchanged, next full frame decodes correctly.
- 26 sck clocks in a write frame to addr 2 = 0x1234 -> regs[2]=0x1234 committed at bit 24, frame_err pulse at cs rise.
- Assert rst_n low during the DATA phase of a write -> outputs at reset values, register untouched, no frame_err; minimum-timing SCK (8 CLK period) back-to-back frames pass.
